// File: rtl/sap1_fetch_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : sap1_fetch_store_unit
// Brief    : Memory-side responder for the SAP1 sequencer; performs instruction
//            fetches into the IR and ALU-result stores over a req/ack RAM port.
// Revision : 1.0 - initial release
// ============================================================================
module sap1_fetch_store_unit #(
    parameter int              ADDR_W     = 4,
    parameter int              DATA_W     = 8,
    parameter logic [3:0]      HLT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        control_signals,
    input  logic              alu_out_en,
    input  logic [DATA_W-1:0] alu_result,
    output logic [3:0]        opcode,
    output logic [ADDR_W-1:0] operand,
    output logic              instr_valid,
    output logic              fetch_done,
    output logic              store_done,
    output logic              busy,
    output logic              halted,
    output logic              seq_err,
    output logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FETCH_WAIT = 2'd1,
        S_STORE_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_ir;

    logic w_fetch;
    logic w_store;
    logic w_unused;

    assign w_fetch  = control_signals[0];
    assign w_store  = control_signals[4];
    // Decode needs no action: the IR fields are already registered outputs.
    assign w_unused = ^{control_signals[7:5], control_signals[3:1]};

    assign opcode  = r_ir[DATA_W-1 -: 4];
    assign operand = r_ir[ADDR_W-1:0];
    assign busy    = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_store) begin
                    if (alu_out_en) begin
                        w_state_nxt = S_STORE_WAIT;
                    end
                end else if (w_fetch && !halted) begin
                    w_state_nxt = S_FETCH_WAIT;
                end
            end
            S_FETCH_WAIT: begin
                if (mem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STORE_WAIT: begin
                if (mem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir        <= '0;
            pc          <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            seq_err     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            fetch_done  <= 1'b0;
            store_done  <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            store_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_store) begin
                        mem_wdata <= alu_result;
                        mem_addr  <= operand;
                        if (alu_out_en) begin
                            mem_we  <= 1'b1;
                            mem_req <= 1'b1;
                        end else begin
                            store_done <= 1'b1;
                        end
                        // Store takes priority; a colliding fetch is dropped.
                        if (w_fetch) begin
                            seq_err <= 1'b1;
                        end
                    end else if (w_fetch) begin
                        if (halted) begin
                            seq_err <= 1'b1;
                        end else begin
                            mem_addr    <= pc;
                            mem_we      <= 1'b0;
                            mem_req     <= 1'b1;
                            instr_valid <= 1'b0;
                        end
                    end
                end
                S_FETCH_WAIT: begin
                    if (w_fetch || w_store) begin
                        seq_err <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_ir        <= mem_rdata;
                        pc          <= pc + ADDR_W'(1);
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                        fetch_done  <= 1'b1;
                        if (mem_rdata[DATA_W-1 -: 4] == HLT_OPCODE) begin
                            halted <= 1'b1;
                        end
                    end
                end
                S_STORE_WAIT: begin
                    if (w_fetch || w_store) begin
                        seq_err <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        store_done <= 1'b1;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sap1_fetch_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_sap1_fetch_store_unit
// Brief    : Directed self-checking bench for sap1_fetch_store_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sap1_fetch_store_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] control_signals;
    logic       alu_out_en;
    logic [7:0] alu_result;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       instr_valid, fetch_done, store_done, busy, halted, seq_err;
    logic [3:0] pc;
    logic       mem_req, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    sap1_fetch_store_unit dut (
        .clk             (clk),
        .reset           (reset),
        .control_signals (control_signals),
        .alu_out_en      (alu_out_en),
        .alu_result      (alu_result),
        .opcode          (opcode),
        .operand         (operand),
        .instr_valid     (instr_valid),
        .fetch_done      (fetch_done),
        .store_done      (store_done),
        .busy            (busy),
        .halted          (halted),
        .seq_err         (seq_err),
        .pc              (pc),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        control_signals = 8'h00;
        alu_out_en      = 1'b0;
        alu_result      = 8'h00;
        mem_ack         = 1'b0;
        mem_rdata       = 8'h00;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_pc", pc, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
        chk("rst_ivalid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_seqerr", seq_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_done", {fetch_done, store_done}, 0);
        reset = 1'b0;

        // 1: zero-wait fetch of 8'h13 from address 0
        control_signals = 8'h01;
        tick();
        control_signals = 8'h00;
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 0);
        chk("t1_we", mem_we, 0);
        chk("t1_busy", busy, 1);
        chk("t1_fdone_early", fetch_done, 0);
        mem_ack   = 1'b1;
        mem_rdata = 8'h13;
        tick();
        mem_ack = 1'b0;
        chk("t1_fdone", fetch_done, 1);
        chk("t1_opcode", opcode, 4'h1);
        chk("t1_operand", operand, 4'h3);
        chk("t1_pc", pc, 1);
        chk("t1_ivalid", instr_valid, 1);
        chk("t1_req_drop", mem_req, 0);
        tick();
        chk("t1_fdone_pulse", fetch_done, 0);

        // Ack while idle and a decode strobe must both be ignored
        mem_ack         = 1'b1;
        control_signals = 8'h02;
        tick();
        mem_ack         = 1'b0;
        control_signals = 8'h00;
        chk("idle_ack_req", mem_req, 0);
        chk("idle_ack_pc", pc, 1);
        chk("idle_ack_done", {fetch_done, store_done}, 0);
        chk("idle_ack_ir", {opcode, operand}, 8'h13);

        // 2: fetch with 3 wait cycles; fetch strobe during the wait
        control_signals = 8'h01;
        tick();
        for (int i = 0; i < 4; i++) begin
            control_signals = (i == 0) ? 8'h01 : 8'h00;
            chk($sformatf("t2_req_%0d", i), mem_req, 1);
            chk($sformatf("t2_addr_%0d", i), mem_addr, 1);
            chk($sformatf("t2_busy_%0d", i), busy, 1);
            chk($sformatf("t2_fdone_%0d", i), fetch_done, 0);
            chk($sformatf("t2_ivalid_%0d", i), instr_valid, 0);
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'h29;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("t2_seqerr", seq_err, 1);
        chk("t2_fdone", fetch_done, 1);
        chk("t2_ir", {opcode, operand}, 8'h29);
        chk("t2_pc", pc, 2);
        tick();
        chk("t2_fdone_once", fetch_done, 0);
        chk("t2_no_second_req", mem_req, 0);

        // 3: store A5 to operand address 9 with one wait cycle
        control_signals = 8'h10;
        alu_out_en      = 1'b1;
        alu_result      = 8'hA5;
        tick();
        control_signals = 8'h00;
        alu_out_en      = 1'b0;
        alu_result      = 8'h00;
        chk("t3_req", mem_req, 1);
        chk("t3_we", mem_we, 1);
        chk("t3_addr", mem_addr, 9);
        chk("t3_wdata", mem_wdata, 8'hA5);
        chk("t3_busy", busy, 1);
        tick();
        chk("t3_wdata_hold", mem_wdata, 8'hA5);
        chk("t3_addr_hold", mem_addr, 9);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t3_sdone", store_done, 1);
        chk("t3_req_drop", mem_req, 0);
        chk("t3_we_drop", mem_we, 0);
        chk("t3_pc", pc, 2);
        chk("t3_ir", {opcode, operand}, 8'h29);
        tick();
        chk("t3_sdone_pulse", store_done, 0);

        // 4a: store with alu_out_en low is skipped but still completes
        control_signals = 8'h10;
        alu_out_en      = 1'b0;
        alu_result      = 8'h77;
        tick();
        control_signals = 8'h00;
        chk("t4_skip_req", mem_req, 0);
        chk("t4_skip_sdone", store_done, 1);
        chk("t4_skip_busy", busy, 0);
        tick();
        chk("t4_skip_sdone_pulse", store_done, 0);

        // 4b: fetch+store collision after a clean reset
        apply_reset();
        chk("t4_rst_seqerr", seq_err, 0);
        @(negedge clk);
        control_signals = 8'h11;
        alu_out_en      = 1'b1;
        alu_result      = 8'h3C;
        tick();
        control_signals = 8'h00;
        alu_out_en      = 1'b0;
        chk("t4_col_we", mem_we, 1);
        chk("t4_col_wdata", mem_wdata, 8'h3C);
        chk("t4_col_addr", mem_addr, 0);
        chk("t4_col_seqerr", seq_err, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t4_col_sdone", store_done, 1);
        chk("t4_col_fdone", fetch_done, 0);
        chk("t4_col_pc", pc, 0);

        // 5: walk pc to F, fetch HLT there, wrap and halt
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            control_signals = 8'h01;
            tick();
            control_signals = 8'h00;
            mem_ack   = 1'b1;
            mem_rdata = 8'h00;
            tick();
            mem_ack = 1'b0;
        end
        chk("t5_pc_f", pc, 4'hF);
        chk("t5_seqerr_clean", seq_err, 0);
        control_signals = 8'h01;
        tick();
        control_signals = 8'h00;
        chk("t5_addr_f", mem_addr, 4'hF);
        mem_ack   = 1'b1;
        mem_rdata = 8'hF0;
        tick();
        mem_ack = 1'b0;
        chk("t5_pc_wrap", pc, 0);
        chk("t5_halted", halted, 1);
        chk("t5_opcode", opcode, 4'hF);
        chk("t5_fdone", fetch_done, 1);
        control_signals = 8'h01;
        tick();
        control_signals = 8'h00;
        chk("t5_halt_noreq", mem_req, 0);
        chk("t5_halt_busy", busy, 0);
        chk("t5_halt_seqerr", seq_err, 1);
        apply_reset();
        chk("t5_rst_halted", halted, 0);

        // 6: reset mid-fetch drops the request asynchronously
        @(negedge clk);
        control_signals = 8'h01;
        tick();
        control_signals = 8'h00;
        tick();
        chk("t6_req_pre", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_req_async", mem_req, 0);
        chk("t6_busy_async", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("t6_fdone", fetch_done, 0);
        chk("t6_pc", pc, 0);
        chk("t6_ivalid", instr_valid, 0);
        chk("t6_req_after", mem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
